// File: rtl/wb_hilo_regfile_pkg.sv
// hilo_pkg: shared op codes, FSM state type and default width for the
// Hi/Lo register pair and its adder.
package hilo_pkg;

   localparam int HILO_DATA_W = 32;

   localparam logic [3:0] HILO_OP_NONE = 4'd0;
   localparam logic [3:0] HILO_OP_MTHI = 4'd1;
   localparam logic [3:0] HILO_OP_MTLO = 4'd2;
   localparam logic [3:0] HILO_OP_MULT = 4'd3;
   localparam logic [3:0] HILO_OP_MADD = 4'd4;
   localparam logic [3:0] HILO_OP_MSUB = 4'd5;

   typedef enum logic [0:0] {
      HILO_IDLE   = 1'b0,
      HILO_ACC_HI = 1'b1
   } hilo_state_e;

   // True for the two-cycle accumulate ops (madd / msub).
   function automatic logic hilo_is_acc(input logic [3:0] op);
      return (op == HILO_OP_MADD) || (op == HILO_OP_MSUB);
   endfunction

endpackage

// File: rtl/wb_hilo_regfile_if.sv
// Bus between the MEM-stage HiLo product unit / forwarding path and the
// architectural Hi/Lo register pair.
interface wb_hilo_regfile_if #(
   parameter int DATA_W = 32
);
   logic                  Valid;
   logic [3:0]            Op;
   logic [2*DATA_W-1:0]   Product;
   logic                  Busy;
   logic [DATA_W-1:0]     Hi;
   logic [DATA_W-1:0]     Lo;

   modport master (
      output Valid, Op, Product,
      input  Busy, Hi, Lo
   );

   modport slave (
      input  Valid, Op, Product,
      output Busy, Hi, Lo
   );
endinterface

// File: rtl/wb_hilo_regfile_add32.sv
// hilo_add32: DATA_W-bit adder with carry-in and carry-out, shared between
// the Lo half and the Hi half of an accumulate.
module hilo_add32 #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

endmodule

// File: rtl/wb_hilo_regfile.sv
// wb_hilo_regfile: architectural Hi/Lo register pair. Commits mthi, mtlo,
// mult in one cycle; madd/msub take two cycles (Lo half, then Hi half with
// the latched carry) and raise Busy for the second cycle.
// Optional macro HILO_BYPASS_EN: forward mthi/mtlo/mult write data onto
// Hi/Lo combinationally in the accept cycle.
module wb_hilo_regfile
   import hilo_pkg::*;
#(
   parameter int DATA_W = HILO_DATA_W
) (
   input  logic                Clk,
   input  logic                Reset,
   wb_hilo_regfile_if.slave    bus
);

   hilo_state_e        state_r;
   hilo_state_e        state_nxt_s;
   logic [DATA_W-1:0]  hi_r;
   logic [DATA_W-1:0]  lo_r;
   logic [DATA_W-1:0]  hi_nxt_s;
   logic [DATA_W-1:0]  lo_nxt_s;
   logic               busy_r;
   logic               busy_nxt_s;
   logic               carry_r;
   logic               carry_nxt_s;
   logic [DATA_W-1:0]  opnd_r;
   logic [DATA_W-1:0]  opnd_nxt_s;

   logic [DATA_W-1:0]  prod_lo_s;
   logic [DATA_W-1:0]  prod_hi_s;
   logic [DATA_W-1:0]  add_a_s;
   logic [DATA_W-1:0]  add_b_s;
   logic               add_cin_s;
   logic [DATA_W-1:0]  add_sum_s;
   logic               add_cout_s;

   assign prod_lo_s = bus.Product[DATA_W-1:0];
   assign prod_hi_s = bus.Product[2*DATA_W-1:DATA_W];

   // Steer the shared adder: Lo + (+/-)Product_lo in IDLE, Hi + latched half in ACC_HI.
   always_comb begin
      add_a_s   = lo_r;
      add_b_s   = prod_lo_s;
      add_cin_s = 1'b0;
      case (state_r)
         HILO_IDLE: begin
            add_a_s = lo_r;
            if (bus.Op == HILO_OP_MSUB) begin
               add_b_s   = ~prod_lo_s;
               add_cin_s = 1'b1;
            end else begin
               add_b_s   = prod_lo_s;
               add_cin_s = 1'b0;
            end
         end
         HILO_ACC_HI: begin
            add_a_s   = hi_r;
            add_b_s   = opnd_r;
            add_cin_s = carry_r;
         end
         default: begin
            add_a_s   = lo_r;
            add_b_s   = prod_lo_s;
            add_cin_s = 1'b0;
         end
      endcase
   end

   hilo_add32 #(.DATA_W(DATA_W)) u_add (
      .a    (add_a_s),
      .b    (add_b_s),
      .cin  (add_cin_s),
      .sum  (add_sum_s),
      .cout (add_cout_s)
   );

   // Next-state and next-register values; ops presented in ACC_HI are dropped.
   always_comb begin
      state_nxt_s = state_r;
      hi_nxt_s    = hi_r;
      lo_nxt_s    = lo_r;
      busy_nxt_s  = 1'b0;
      carry_nxt_s = carry_r;
      opnd_nxt_s  = opnd_r;
      case (state_r)
         HILO_IDLE: begin
            if (bus.Valid) begin
               case (bus.Op)
                  HILO_OP_MTHI: hi_nxt_s = prod_lo_s;
                  HILO_OP_MTLO: lo_nxt_s = prod_lo_s;
                  HILO_OP_MULT: begin
                     hi_nxt_s = prod_hi_s;
                     lo_nxt_s = prod_lo_s;
                  end
                  HILO_OP_MADD: begin
                     lo_nxt_s    = add_sum_s;
                     carry_nxt_s = add_cout_s;
                     opnd_nxt_s  = prod_hi_s;
                     busy_nxt_s  = 1'b1;
                     state_nxt_s = HILO_ACC_HI;
                  end
                  HILO_OP_MSUB: begin
                     lo_nxt_s    = add_sum_s;
                     carry_nxt_s = add_cout_s;
                     opnd_nxt_s  = ~prod_hi_s;
                     busy_nxt_s  = 1'b1;
                     state_nxt_s = HILO_ACC_HI;
                  end
                  default: state_nxt_s = HILO_IDLE;
               endcase
            end else begin
               state_nxt_s = HILO_IDLE;
            end
         end
         HILO_ACC_HI: begin
            hi_nxt_s    = add_sum_s;
            state_nxt_s = HILO_IDLE;
         end
         default: state_nxt_s = HILO_IDLE;
      endcase
   end

   // State and Hi/Lo registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= HILO_IDLE;
         hi_r    <= {DATA_W{1'b0}};
         lo_r    <= {DATA_W{1'b0}};
         busy_r  <= 1'b0;
         carry_r <= 1'b0;
         opnd_r  <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         hi_r    <= hi_nxt_s;
         lo_r    <= lo_nxt_s;
         busy_r  <= busy_nxt_s;
         carry_r <= carry_nxt_s;
         opnd_r  <= opnd_nxt_s;
      end
   end

   assign bus.Busy = busy_r;

`ifdef HILO_BYPASS_EN
   logic byp_hi_s;
   logic byp_lo_s;

   // Zero-latency forwarding of single-cycle writes; accumulates never bypass.
   always_comb begin
      byp_hi_s = 1'b0;
      byp_lo_s = 1'b0;
      if (!Reset && (state_r == HILO_IDLE) && bus.Valid && !hilo_is_acc(bus.Op)) begin
         byp_hi_s = (bus.Op == HILO_OP_MTHI) || (bus.Op == HILO_OP_MULT);
         byp_lo_s = (bus.Op == HILO_OP_MTLO) || (bus.Op == HILO_OP_MULT);
      end else begin
         byp_hi_s = 1'b0;
         byp_lo_s = 1'b0;
      end
   end

   assign bus.Hi = byp_hi_s ? hi_nxt_s : hi_r;
   assign bus.Lo = byp_lo_s ? lo_nxt_s : lo_r;
`else
   assign bus.Hi = hi_r;
   assign bus.Lo = lo_r;
`endif

endmodule

// File: tb/tb_wb_hilo_regfile.sv
// Self-checking bench for wb_hilo_regfile: directed scenarios followed by
// random op streams compared against a 64-bit {Hi,Lo} reference model.
module tb_wb_hilo_regfile;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [63:0] m_hilo;

   wb_hilo_regfile_if #(.DATA_W(32)) bus();

   wb_hilo_regfile #(.DATA_W(32)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle with the given op presented; returns #1 after the accepting edge.
   task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] p);
      @(negedge clk);
      bus.Valid   = v;
      bus.Op      = op;
      bus.Product = p;
      @(posedge clk);
      #1;
      bus.Valid   = 1'b0;
      bus.Op      = 4'd0;
      bus.Product = 64'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_hilo = 64'd0;
   endtask

   // Architectural effect of one accepted op on the 64-bit pair.
   function automatic logic [63:0] model(input logic [63:0] hl, input logic [3:0] op,
                                         input logic [63:0] p);
      case (op)
         4'd1:    return {p[31:0], hl[31:0]};
         4'd2:    return {hl[63:32], p[31:0]};
         4'd3:    return p;
         4'd4:    return hl + p;
         4'd5:    return hl - p;
         default: return hl;
      endcase
   endfunction

   function automatic logic [63:0] hilo();
      return {bus.Hi, bus.Lo};
   endfunction

   initial begin
      logic [3:0]  op;
      logic        v;
      logic [63:0] p;
      logic [63:0] nxt;
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.Valid   = 1'b0;
      bus.Op      = 4'd0;
      bus.Product = 64'd0;
      m_hilo      = 64'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_hilo", hilo(), 64'd0);
      chk("reset_busy", {63'd0, bus.Busy}, 64'd0);

      // mult
      drive(1'b1, 4'd3, 64'h00000001_80000000);
      chk("mult_hilo", hilo(), 64'h00000001_80000000);
      chk("mult_busy", {63'd0, bus.Busy}, 64'd0);

      // madd carry from Lo into Hi
      drive(1'b1, 4'd2, 64'h00000000_FFFFFFFF);
      drive(1'b1, 4'd1, 64'd0);
      chk("madd_pre", hilo(), 64'h00000000_FFFFFFFF);
      drive(1'b1, 4'd4, 64'd1);
      chk("madd_t1_hilo", hilo(), 64'h00000000_00000000);
      chk("madd_t1_busy", {63'd0, bus.Busy}, 64'd1);
      drive(1'b0, 4'd0, 64'd0);
      chk("madd_t2_hilo", hilo(), 64'h00000001_00000000);
      chk("madd_t2_busy", {63'd0, bus.Busy}, 64'd0);

      // msub borrow
      drive(1'b1, 4'd1, 64'd0);
      drive(1'b1, 4'd2, 64'd0);
      drive(1'b1, 4'd5, 64'd1);
      chk("msub_t1_hilo", hilo(), 64'h00000000_FFFFFFFF);
      chk("msub_t1_busy", {63'd0, bus.Busy}, 64'd1);
      drive(1'b0, 4'd0, 64'd0);
      chk("msub_t2_hilo", hilo(), 64'hFFFFFFFF_FFFFFFFF);
      chk("msub_t2_busy", {63'd0, bus.Busy}, 64'd0);

      // back-to-back mthi / mtlo
      drive(1'b1, 4'd1, 64'h00000000_DEADBEEF);
      chk("mthi_hi", {32'd0, bus.Hi}, 64'h00000000_DEADBEEF);
      drive(1'b1, 4'd2, 64'h00000000_12345678);
      chk("mthi_mtlo", hilo(), 64'hDEADBEEF_12345678);

      // ops 6..15 ignored
      drive(1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("op9_nochange", hilo(), 64'hDEADBEEF_12345678);

      // op presented while Busy is dropped
      drive(1'b1, 4'd4, 64'h00000002_00000003);
      drive(1'b1, 4'd3, 64'hAAAAAAAA_55555555);
      chk("drop_hilo", hilo(), 64'hDEADBEF1_1234567B);
      chk("drop_busy", {63'd0, bus.Busy}, 64'd0);
      drive(1'b0, 4'd0, 64'd0);
      chk("drop_hold", hilo(), 64'hDEADBEF1_1234567B);

      // reset while in ACC_HI
      drive(1'b1, 4'd4, 64'h00000007_00000001);
      do_reset();
      chk("rst_acc_hilo", hilo(), 64'd0);
      chk("rst_acc_busy", {63'd0, bus.Busy}, 64'd0);
      drive(1'b1, 4'd2, 64'd5);
      chk("rst_acc_mtlo", hilo(), 64'h00000000_00000005);
      m_hilo = 64'h00000000_00000005;

`ifdef HILO_BYPASS_EN
      // same-cycle forwarding
      @(negedge clk);
      bus.Valid   = 1'b1;
      bus.Op      = 4'd1;
      bus.Product = 64'h00000000_CAFEF00D;
      #1;
      chk("bypass_hi", {32'd0, bus.Hi}, 64'h00000000_CAFEF00D);
      @(posedge clk);
      #1;
      bus.Valid = 1'b0;
      bus.Op    = 4'd0;
      m_hilo    = {32'hCAFEF00D, m_hilo[31:0]};
      chk("bypass_reg", hilo(), m_hilo);
`endif

      // random ops against the reference model
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom % 4) != 0;
         op = (($urandom % 4) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
         p  = {$urandom, $urandom};
         drive(v, op, p);
         if (v && (op == 4'd4 || op == 4'd5)) begin
            nxt = model(m_hilo, op, p);
            chk("rnd_acc_t1", hilo(), {m_hilo[63:32], nxt[31:0]});
            chk("rnd_acc_busy1", {63'd0, bus.Busy}, 64'd1);
            drive(($urandom % 2) != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom});
            m_hilo = nxt;
            chk("rnd_acc_t2", hilo(), m_hilo);
            chk("rnd_acc_busy2", {63'd0, bus.Busy}, 64'd0);
         end else begin
            if (v) m_hilo = model(m_hilo, op, p);
            chk("rnd_single", hilo(), m_hilo);
            chk("rnd_single_busy", {63'd0, bus.Busy}, 64'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_hilo_regfile.md
# wb_hilo_regfile

Architectural Hi/Lo register pair for the datapath, directly downstream of the MEM-stage HiLo product unit. It consumes that unit's 64-bit `Product` and 4-bit op code, then commits `mthi`, `mtlo`, `mult`, `madd` and `msub` results into Hi/Lo. Accumulate ops use a two-cycle split 64-bit add/subtract, with `Busy` back-pressure to the pipeline. `Hi` and `Lo` feed the ID/EX forwarding path for `mfhi`/`mflo`.

## Interface
- `DATA_W`, 32, width of each of Hi and Lo; `Product` is 2*`DATA_W`.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Valid`  in  1  `Op`/`Product` are valid this cycle.
- `Op`  in  4  op code:
  - 0: none
  - 1: mthi
  - 2: mtlo
  - 3: mult
  - 4: madd
  - 5: msub
  - 6–15: treated as none.
- `Product`  in  64  for ops 1 and 2, value in [31:0]; for ops 3–5, full 64-bit product.
- `Busy`  out  1  accumulate second half in progress; upstream must hold.
- `Hi`  out  32  committed Hi value.
- `Lo`  out  32  committed Lo value.

## Operation
- FSM states:
  - IDLE: accepts ops.
  - ACC_HI: finishes an accumulate.
- IDLE with `Valid`=1:
  - Op 1: Hi <= `Product`[31:0].
  - Op 2: Lo <= `Product`[31:0].
  - Op 3: {Hi,Lo} <= `Product`.
  - Op 4 (madd): Lo <= Lo + `Product`[31:0].
  - Op 5 (msub): Lo <= Lo + ~`Product`[31:0] + 1.
  - Ops 4 and 5 also: latch carry-out and the operand `Product`[63:32] (op 4) or ~`Product`[63:32] (op 5); go to ACC_HI.
  - Ops 0 and 6–15: no change.
- IDLE with `Valid`=0: no change.
- ACC_HI: Hi <= Hi + latched operand + latched carry; return to IDLE.
- In ACC_HI, `Valid`/`Op` are ignored. Upstream must not present a new op while `Busy`=1. A presented op is dropped, not queued.
- Arithmetic is modulo 2^64. Overflow and carry out of bit 63 are discarded; there are no flags.
- Signedness is already resolved in `Product`; this block is sign-agnostic.

## Timing
- Reset values: `Hi`=0, `Lo`=0, `Busy`=0, state IDLE, carry and latched operand 0.
- Ops 1/2/3 accepted at edge T: visible on `Hi`/`Lo` in cycle T+1.
- Ops 4/5 accepted at edge T:
  - `Lo` new and `Busy`=1 in cycle T+1.
  - `Hi` new and `Busy`=0 in cycle T+2.
  - Next op is accepted at edge T+2.
- `Busy` is a registered output: high for exactly one cycle per accumulate.
- Reset has priority over everything. Reset in ACC_HI discards the pending Hi update; outputs go to reset values the next cycle.
- Back-to-back single-cycle ops are accepted every cycle.

## Configuration
- `HILO_BYPASS_EN` defined: while in IDLE with `Valid` and op 1, 2 or 3, the affected `Hi`/`Lo` outputs combinationally show the value being written in the same cycle (zero-latency forwarding to `mfhi`/`mflo`). Accumulates are never bypassed. `Busy` is unaffected.
- Not defined: `Hi`/`Lo` are purely registered, with one-cycle visibility as in Timing.

## Structure
- Package `hilo_pkg`:
  - localparams for op codes `HILO_OP_NONE` … `HILO_OP_MSUB`
  - FSM state typedef {`HILO_IDLE`, `HILO_ACC_HI`}
  - `DATA_W` default.
- Sub-module `hilo_add32`: `DATA_W`-bit adder with carry-in/carry-out. Instantiated once and shared between the Lo cycle (carry-in 0 for madd, 1 for msub) and the Hi cycle (latched carry), muxed on state.

## Test plan
- Reset, then mult with `Product`=0x00000001_80000000 -> cycle T+1: `Hi`=0x00000001, `Lo`=0x80000000; `Busy` stays 0.
- `Lo`=0xFFFFFFFF, `Hi`=0, madd with `Product`=1 -> T+1: `Lo`=0, `Busy`=1; T+2: `Hi`=1, `Busy`=0.
- `Hi`=`Lo`=0, msub with `Product`=1 -> T+2: `Hi`=`Lo`=0xFFFFFFFF.
- mthi 0xDEADBEEF then mtlo 0x12345678 on consecutive cycles -> both visible. With `HILO_BYPASS_EN`, each is visible in its own accept cycle.
- madd accepted, then mult presented during `Busy` -> mult dropped; `Hi`/`Lo` equal the madd result.
- madd accepted, `Reset` asserted in ACC_HI -> next cycle `Hi`=`Lo`=0, `Busy`=0; a following mtlo 5 gives `Lo`=5.
